// File: rtl/mg_booth_csa_seq_pkg.sv
// Shared types, constants and Booth digit decoder for the sequential
// radix-4 Booth multiplier with a carry-save accumulator.
package mg_booth_csa_seq_pkg;

  localparam int XW    = 16;
  localparam int PW    = 31;
  localparam int NSTEP = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_POS1 = 3'd1,
    BD_POS2 = 3'd2,
    BD_NEG1 = 3'd3,
    BD_NEG2 = 3'd4
  } booth_t;

  // Triplet is {y[2k+1], y[2k], y[2k-1]}.
  function automatic booth_t booth_decode(input logic [2:0] trip);
    booth_t d;
    case (trip)
      3'b000:  d = BD_ZERO;
      3'b001:  d = BD_POS1;
      3'b010:  d = BD_POS1;
      3'b011:  d = BD_POS2;
      3'b100:  d = BD_NEG2;
      3'b101:  d = BD_NEG1;
      3'b110:  d = BD_NEG1;
      3'b111:  d = BD_ZERO;
      default: d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mg_booth_csa_seq_csa42.sv
// W-bit 4:2 compressor built from two 3:2 carry-save rows; the top carry
// is dropped so o_sum + o_carry == i_a + i_b + i_c + i_d (mod 2^W).
module mg_csa42 #(
  parameter int W = 31
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);
  import mg_booth_csa_seq_pkg::*;

  logic [W-1:0] w_s1;
  logic [W-1:0] w_c1;

  assign w_s1 = i_a ^ i_b ^ i_c;
  assign w_c1 = {((i_a[W-2:0] & i_b[W-2:0]) |
                  (i_a[W-2:0] & i_c[W-2:0]) |
                  (i_b[W-2:0] & i_c[W-2:0])), 1'b0};

  assign o_sum   = w_s1 ^ w_c1 ^ i_d;
  assign o_carry = {((w_s1[W-2:0] & w_c1[W-2:0]) |
                     (w_s1[W-2:0] & i_d[W-2:0])  |
                     (w_c1[W-2:0] & i_d[W-2:0])), 1'b0};

endmodule

// File: rtl/mg_booth_csa_seq.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle folded
// into a carry-save accumulator; the final carry-propagate add is downstream.
module mg_booth_csa_seq #(
  parameter int XW = 16,
  parameter int PW = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic [XW-1:0] in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_a,
  output logic [PW-1:0] out_b,
  output logic          out_p31
);
  import mg_booth_csa_seq_pkg::*;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_k;
  logic [XW-1:0] r_x;
  logic [XW-1:0] r_y;
  logic [PW-1:0] r_acc_s;
  logic [PW-1:0] r_acc_c;
  logic          r_p31;

  logic          w_accept;
  logic          w_step;
  logic          w_last;
  logic [3:0]    w_shamt;
  logic [XW:0]   w_yext;
  logic [2:0]    w_trip;
  booth_t        w_digit;
  logic          w_neg;
  logic [PW-1:0] w_x1;
  logic [PW-1:0] w_x2;
  logic [PW-1:0] w_mag;
  logic [PW-1:0] w_pp;
  logic [PW-1:0] w_corr;
  logic [PW-1:0] w_sum_nxt;
  logic [PW-1:0] w_carry_nxt;

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_step    = (r_state == ST_RUN);
  assign w_last    = (r_k == 3'(NSTEP - 1));

  assign out_valid = (r_state == ST_DONE);
  assign out_a     = r_acc_s;
  assign out_b     = r_acc_c;
  assign out_p31   = r_p31;

  // Booth triplet for step k, with an implicit y[-1] = 0 below bit 0.
  assign w_shamt = {r_k, 1'b0};
  assign w_yext  = {r_y, 1'b0};
  assign w_trip  = w_yext[w_shamt +: 3];
  assign w_digit = booth_decode(w_trip);

  assign w_x1 = {{(PW - XW){r_x[XW-1]}}, r_x};
  assign w_x2 = {w_x1[PW-2:0], 1'b0};

  always_comb begin
    w_mag = {PW{1'b0}};
    w_neg = 1'b0;
    case (w_digit)
      BD_ZERO: begin
        w_mag = {PW{1'b0}};
        w_neg = 1'b0;
      end
      BD_POS1: w_mag = w_x1;
      BD_POS2: w_mag = w_x2;
      BD_NEG1: begin
        w_mag = w_x1;
        w_neg = 1'b1;
      end
      BD_NEG2: begin
        w_mag = w_x2;
        w_neg = 1'b1;
      end
      default: begin
        w_mag = {PW{1'b0}};
        w_neg = 1'b0;
      end
    endcase
  end

  // Negation is ~mag here plus a +1 correction at bit 2k fed as the 4th word.
  assign w_pp   = (w_neg ? ~w_mag : w_mag) << w_shamt;
  assign w_corr = {{(PW - 1){1'b0}}, w_neg} << w_shamt;

  mg_csa42 #(
    .W(PW)
  ) u_csa42 (
    .i_a    (r_acc_s),
    .i_b    (r_acc_c),
    .i_c    (w_pp),
    .i_d    (w_corr),
    .o_sum  (w_sum_nxt),
    .o_carry(w_carry_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_nxt = ST_RUN;
        else          w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) w_state_nxt = ST_RUN;
          else          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= 3'd0;
      r_x     <= {XW{1'b0}};
      r_y     <= {XW{1'b0}};
      r_acc_s <= {PW{1'b0}};
      r_acc_c <= {PW{1'b0}};
      r_p31   <= 1'b0;
    end else if (w_accept) begin
      r_k     <= 3'd0;
      r_x     <= in_x;
      r_y     <= in_y;
      r_acc_s <= {PW{1'b0}};
      r_acc_c <= {PW{1'b0}};
      r_p31   <= (in_x != {XW{1'b0}}) && (in_y != {XW{1'b0}}) &&
                 (in_x[XW-1] ^ in_y[XW-1]);
    end else if (w_step) begin
      r_k     <= r_k + 3'd1;
      r_acc_s <= w_sum_nxt;
      r_acc_c <= w_carry_nxt;
    end
  end

endmodule

// File: tb/tb_mg_booth_csa_seq.sv
// Self-checking bench: directed and random operand pairs compared against
// a plain integer-multiply reference, plus stall, back-to-back and reset cases.
`timescale 1ns/1ps
module tb_mg_booth_csa_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_x = 16'd0;
  logic [15:0] in_y = 16'd0;
  logic        in_ready;
  logic        out_valid;
  logic        out_p31;
  logic [30:0] out_a;
  logic [30:0] out_b;

  int checks = 0;
  int errors = 0;

  mg_booth_csa_seq #(.XW(16), .PW(31)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_p31  (out_p31)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    int px;
    int py;
    px = int'($signed(x));
    py = int'($signed(y));
    return 32'(px * py);
  endfunction

  function automatic logic [30:0] cs_sum();
    logic [30:0] s;
    s = out_a + out_b;
    return s;
  endfunction

  // Offer a pair until accepted; leaves time at accept edge + 1.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, output bit ok);
    ok = 1'b0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    for (int n = 0; n < 30 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_x = 16'($urandom);
    in_y = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++;
    if (out_a !== 31'd0 || out_b !== 31'd0) begin
      errors++; $display("FAIL reset_acc got a=%h b=%h want 0", out_a, out_b);
    end
    checks++;
    if (out_p31 !== 1'b0) begin errors++; $display("FAIL reset_p31 got %b want 0", out_p31); end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] xs [4];
    logic [15:0] ys [4];
    logic [30:0] es [4];
    logic        ps [4];
    bit ok;
    int lat;
    xs = '{16'd3, 16'h8000, 16'hFFFF, 16'd0};
    ys = '{16'd5, 16'h8000, 16'd1, 16'hFFFB};
    es = '{31'd15, 31'h40000000, 31'h7FFFFFFF, 31'd0};
    ps = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(xs[i], ys[i], ok);
      wait_valid(lat);
      checks++;
      if (!ok || lat != 8) begin
        errors++; $display("FAIL dir%0d_latency got %0d (accepted=%0d) want 8", i, lat, ok);
      end
      checks++;
      if (cs_sum() !== es[i]) begin
        errors++; $display("FAIL dir%0d_sum got %h want %h", i, cs_sum(), es[i]);
      end
      checks++;
      if (out_p31 !== ps[i]) begin
        errors++; $display("FAIL dir%0d_p31 got %b want %b", i, out_p31, ps[i]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] exp;
    bit ok;
    int lat;
    int stall;
    for (int i = 0; i < 24; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i == 0) begin x = 16'h7FFF; y = 16'h7FFF; end
      if (i == 1) begin x = 16'h8000; y = 16'h7FFF; end
      if (i == 2) begin x = 16'h7FFF; y = 16'h8000; end
      exp = ref_prod(x, y);
      issue(x, y, ok);
      wait_valid(lat);
      stall = $urandom_range(0, 3);
      repeat (stall) @(posedge clk);
      #1;
      checks++;
      if (!ok || lat != 8 || out_valid !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_handshake lat=%0d valid=%b want 8/1", i, lat, out_valid);
      end
      checks++;
      if (cs_sum() !== exp[30:0] || out_p31 !== exp[31]) begin
        errors++;
        $display("FAIL rnd%0d_product x=%h y=%h got sum=%h p31=%b want %h/%b",
                 i, x, y, cs_sum(), out_p31, exp[30:0], exp[31]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    logic [30:0] a0;
    logic [30:0] b0;
    logic        p0;
    bit ok;
    int lat;
    int bad;
    exp = ref_prod(16'd1234, 16'hFFB3);
    issue(16'd1234, 16'hFFB3, ok);
    wait_valid(lat);
    a0 = out_a;
    b0 = out_b;
    p0 = out_p31;
    checks++;
    if (!ok || lat != 8 || cs_sum() !== exp[30:0] || p0 !== exp[31]) begin
      errors++; $display("FAIL stall_result lat=%0d got %h/%b want %h/%b", lat, cs_sum(), p0, exp[30:0], exp[31]);
    end
    bad = 0;
    in_valid = 1'b1;
    in_x = 16'h5A5A;
    in_y = 16'h0F0F;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_a !== a0 || out_b !== b0 || out_p31 !== p0 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_consume got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1;
    logic [31:0] exp2;
    bit ok;
    int lat;
    int lat2;
    exp1 = ref_prod(16'hFF00, 16'd300);
    exp2 = ref_prod(16'd4321, 16'hA001);
    issue(16'hFF00, 16'd300, ok);
    wait_valid(lat);
    checks++;
    if (!ok || lat != 8 || cs_sum() !== exp1[30:0] || out_p31 !== exp1[31]) begin
      errors++; $display("FAIL b2b_first lat=%0d got %h/%b want %h/%b", lat, cs_sum(), out_p31, exp1[30:0], exp1[31]);
    end
    in_x = 16'd4321;
    in_y = 16'hA001;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = 16'h1111;
    in_y = 16'h2222;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got valid=%b ready=%b want 0/0", out_valid, in_ready);
    end
    wait_valid(lat2);
    checks++;
    if (lat2 + 1 != 9) begin errors++; $display("FAIL b2b_interval got %0d want 9", lat2 + 1); end
    checks++;
    if (cs_sum() !== exp2[30:0] || out_p31 !== exp2[31]) begin
      errors++; $display("FAIL b2b_second got %h/%b want %h/%b", cs_sum(), out_p31, exp2[30:0], exp2[31]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int lat;
    int seen;
    issue(16'h8001, 16'd3, ok);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_a !== 31'd0 || out_b !== 31'd0 || out_p31 !== 1'b0) begin
      errors++; $display("FAIL midrst_async got valid=%b a=%h b=%h p31=%b want all 0", out_valid, out_a, out_b, out_p31);
    end
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_valid got %0d pulses want 0", seen); end
    issue(16'd7, 16'hFFF7, ok);
    wait_valid(lat);
    checks++;
    if (!ok || lat != 8 || cs_sum() !== 31'h7FFFFFC1 || out_p31 !== 1'b1) begin
      errors++; $display("FAIL midrst_next lat=%0d got %h/%b want 7fffffc1/1", lat, cs_sum(), out_p31);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
